fp_sqrt_prep: RTL

FP_SQRT_PREP -- requirements
Module: fp_sqrt_prep

---
 rtl/fp_sqrt_pkg.sv | 51 +++++
 rtl/fp_classify.sv | 44 ++++
 rtl/fp_sqrt_prep.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fp_sqrt_pkg.sv
// Shared definitions for the square-root operand preparation block.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
//
// Holds the class encodings, FSM state encoding, exponent bias and field widths,
// plus the exponent-evening helper used on every path into the output state.
package fp_sqrt_pkg;

    localparam int EXP_W      = 8;
    localparam int FRAC_W     = 23;
    localparam int WORD_W     = 1 + EXP_W + FRAC_W;
    localparam int BIAS       = 127;
    localparam int OEXP_W     = 10;
    localparam int MANT_W     = FRAC_W + 2;
    localparam int DENORM_EXP = 1 - BIAS;

    typedef enum logic [2:0] {
        CLS_NORMAL = 3'd0,
        CLS_ZERO   = 3'd1,
        CLS_INF    = 3'd2,
        CLS_NAN    = 3'd3,
        CLS_NEG    = 3'd4
    } fp_class_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [OEXP_W-1:0] e;
        logic [MANT_W-1:0] m;
    } prep_t;

    // sqrt halves the exponent, so it must be even: an odd exponent trades
    // one bit of exponent for a doubling of the mantissa (value in [1,4)).
    function automatic prep_t make_even(input logic [OEXP_W-1:0] e,
                                        input logic [MANT_W-1:0] m);
        prep_t r;
        if (e[0]) begin
            r.e = e - OEXP_W'(1);
            r.m = m << 1;
        end else begin
            r.e = e;
            r.m = m;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single classifier and field splitter.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input every cycle.
//
// Ports: op (raw word) -> sign, exp_f, frac fields; cls (fp_class_t code);
// is_denorm flags a positive subnormal (reported as CLS_NORMAL so the caller
// decides whether to normalise or flush it).
module fp_classify
    import fp_sqrt_pkg::*;
(
    input  logic [WORD_W-1:0] op,
    output logic              sign,
    output logic [EXP_W-1:0]  exp_f,
    output logic [FRAC_W-1:0] frac,
    output logic [2:0]        cls,
    output logic              is_denorm
);

    assign sign  = op[WORD_W-1];
    assign exp_f = op[FRAC_W +: EXP_W];
    assign frac  = op[FRAC_W-1:0];

    always_comb begin
        cls       = CLS_NORMAL;
        is_denorm = 1'b0;
        if (exp_f == '1) begin
            // NaN wins over sign; -inf is reported as NEG.
            if (frac != '0)
                cls = CLS_NAN;
            else if (sign)
                cls = CLS_NEG;
            else
                cls = CLS_INF;
        end else if (exp_f == '0 && frac == '0) begin
            // -0 stays ZERO; sign is carried separately.
            cls = CLS_ZERO;
        end else if (sign) begin
            cls = CLS_NEG;
        end else if (exp_f == '0) begin
            is_denorm = 1'b1;
        end
    end

endmodule

// File: rtl/fp_sqrt_prep.sv
// Prepares an IEEE-754 single operand for a sqrt datapath: class, even exponent, mantissa in [1,4).
// Latency: 1 cycle (normals/specials), 1+k cycles for a subnormal needing k normalising shifts.
// Backpressure: single-entry; in_ready only in IDLE, result held in OUT until out_ready.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data (operand in);
// out_valid/out_ready, out_sign, out_class, out_exp (signed, even), out_mant (2.23 fixed).
// Build option: FP_SQRT_PREP_DENORM_EN normalises subnormals; without it they flush to ZERO.
module fp_sqrt_prep
    import fp_sqrt_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic [2:0]            out_class,
    output logic [OEXP_W-1:0]     out_exp,
    output logic [MANT_W-1:0]     out_mant
);

    state_t state, state_nxt;

    logic              c_sign;
    logic [EXP_W-1:0]  c_exp;
    logic [FRAC_W-1:0] c_frac;
    logic [2:0]        c_cls;
    logic              c_denorm;

    logic [2:0]        acc_cls;
    logic              denorm_go;

    logic              sign_q;
    logic [2:0]        cls_q;
    logic [OEXP_W-1:0] e_q;
    logic [MANT_W-1:0] m_q;

    logic [OEXP_W-1:0] e_unb;
    logic [OEXP_W-1:0] e_sh;
    logic [MANT_W-1:0] m_sh;
    prep_t             norm_even;
    prep_t             shift_even;

    fp_classify u_classify (
        .op        (in_data),
        .sign      (c_sign),
        .exp_f     (c_exp),
        .frac      (c_frac),
        .cls       (c_cls),
        .is_denorm (c_denorm)
    );

    // Subnormal policy at acceptance.
    always_comb begin
        acc_cls   = c_cls;
        denorm_go = 1'b0;
        if (c_denorm) begin
`ifdef FP_SQRT_PREP_DENORM_EN
            denorm_go = 1'b1;
`else
            acc_cls   = CLS_ZERO;
`endif
        end
    end

    // Normal operand: implicit leading one sits at bit 23.
    assign e_unb     = OEXP_W'(c_exp) - OEXP_W'(BIAS);
    assign norm_even = make_even(e_unb, {2'b01, c_frac});

    // One normalising step; the step that lands the leading one on bit 23
    // also applies exponent evening before entering OUT.
    assign e_sh       = e_q - OEXP_W'(1);
    assign m_sh       = m_q << 1;
    assign shift_even = make_even(e_sh, m_sh);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = denorm_go ? ST_NORM : ST_OUT;
            ST_NORM: if (m_sh[FRAC_W]) state_nxt = ST_OUT;
            ST_OUT:  if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_OUT);
        out_sign  = sign_q;
        out_class = cls_q;
        out_exp   = e_q;
        out_mant  = m_q;
    end

    // Operand registers: loaded on acceptance, shifted in NORM, frozen in OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            cls_q  <= CLS_NORMAL;
            e_q    <= '0;
            m_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_q <= c_sign;
                        cls_q  <= acc_cls;
                        if (denorm_go) begin
                            e_q <= OEXP_W'(DENORM_EXP);
                            m_q <= {2'b00, c_frac};
                        end else if (acc_cls == CLS_NORMAL) begin
                            e_q <= norm_even.e;
                            m_q <= norm_even.m;
                        end else begin
                            // Specials carry only class and sign.
                            e_q <= '0;
                            m_q <= '0;
                        end
                    end
                end
                ST_NORM: begin
                    if (m_sh[FRAC_W]) begin
                        e_q <= shift_even.e;
                        m_q <= shift_even.m;
                    end else begin
                        e_q <= e_sh;
                        m_q <= m_sh;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
